rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 24 ++
 rtl/rom_loader_if.sv | 29 ++
 rtl/rom_loader_byte_timeout_counter.sv | 30 +++
 rtl/rom_loader.sv | 124 ++++++++++++
 tb/tb_rom_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rom_loader_pkg.sv
// Shared state encoding and frame-format constants for the ROM loader.
package rom_loader_pkg;

  localparam int BYTE_W    = 8;
  localparam int LEN_BYTES = 2;
  localparam int LEN_W     = BYTE_W * LEN_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Receive states are the ones that accept bytes and run the idle timer.
  function automatic logic is_rx(state_t s);
    return s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI, ST_CHECK};
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte stream in, program-memory write port and status out.
interface rom_loader_if
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              i_start;
  logic              i_valid;
  logic [BYTE_W-1:0] i_byte;
  logic              o_ready;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_data;
  logic              o_cpu_rst;
  logic              o_busy;
  logic              o_done;
  logic              o_error;

  modport slave (
    input  i_start, i_valid, i_byte,
    output o_ready, o_we, o_addr, o_data, o_cpu_rst, o_busy, o_done, o_error
  );

  modport master (
    output i_start, i_valid, i_byte,
    input  o_ready, o_we, o_addr, o_data, o_cpu_rst, o_busy, o_done, o_error
  );
endinterface

// File: rtl/rom_loader_byte_timeout_counter.sv
// Idle-cycle counter: tc is high in the cycle that would be the TIMEOUT-th idle cycle.
// Latency: tc is combinational from the count; count updates each core_clk.
// Backpressure: none; clr wins over en.
module byte_timeout_counter #(
  parameter int TIMEOUT = 65535
) (
  input  logic core_clk,
  input  logic arst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = en && !clr && (cnt == LAST);

endmodule

// File: rtl/rom_loader.sv
// Receives a length-prefixed, XOR-checked byte frame and writes 16-bit words to program memory.
// Latency: one write strobe the cycle after each high byte; status is combinational from state.
// Backpressure: never stalls inside a frame; o_ready is purely a function of state.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ROM_DATA_WIDTH = 16,
  parameter int ROM_ADDR_WIDTH = 12,
  parameter int TIMEOUT        = 65535
) (
  input  logic         i_clk,
  input  logic         i_rst,
  rom_loader_if.slave  bus
);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ROM_ADDR_WIDTH;

  state_t state, state_nxt;

  logic                      rx;
  logic                      accept;
  logic                      timeout;
  logic                      oversize;
  logic                      last_word;
  logic [BYTE_W-1:0]         len_lo_q;
  logic [BYTE_W-1:0]         lo_q;
  logic [BYTE_W-1:0]         csum;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          len_in;
  logic [LEN_W:0]            widx;
  logic [ROM_DATA_WIDTH-1:0] wr_data;

  assign rx        = is_rx(state);
  assign accept    = rx && bus.i_valid;
  assign len_in    = {bus.i_byte, len_lo_q};
  assign oversize  = {{(32-LEN_W){1'b0}}, len_in} > MAX_WORDS;
  assign last_word = (widx + (LEN_W+1)'(1)) == {1'b0, len_q};
  assign wr_data   = {bus.i_byte, lo_q};

  assign bus.o_ready   = rx;
  assign bus.o_busy    = rx;
  assign bus.o_done    = (state == ST_DONE);
  assign bus.o_cpu_rst = (state == ST_DONE);
  assign bus.o_error   = (state == ST_ERROR);

  byte_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .core_clk (i_clk),
    .arst_n   (i_rst),
    .clr      (accept || !rx),
    .en       (rx),
    .tc       (timeout)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (bus.i_start) state_nxt = ST_LEN_LO;
      ST_LEN_LO:  if (accept) state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (oversize)          state_nxt = ST_ERROR;
          else if (len_in == '0) state_nxt = ST_CHECK;
          else                   state_nxt = ST_DATA_LO;
        end
      end
      ST_DATA_LO: if (accept) state_nxt = ST_DATA_HI;
      ST_DATA_HI: if (accept) state_nxt = last_word ? ST_CHECK : ST_DATA_LO;
      ST_CHECK:   if (accept) state_nxt = (bus.i_byte == csum) ? ST_DONE : ST_ERROR;
      default:    state_nxt = ST_IDLE;
    endcase
    // Only reachable without an accepted byte, so it never races a transition above.
    if (timeout) state_nxt = ST_ERROR;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bus.o_we   <= 1'b0;
      bus.o_addr <= '0;
      bus.o_data <= '0;
      len_lo_q   <= '0;
      lo_q       <= '0;
      len_q      <= '0;
      csum       <= '0;
      widx       <= '0;
    end else begin
      bus.o_we <= 1'b0;
      if (!rx && bus.i_start) begin
        widx <= '0;
        csum <= '0;
      end
      if (accept) begin
        case (state)
          ST_LEN_LO: begin
            len_lo_q <= bus.i_byte;
            csum     <= csum ^ bus.i_byte;
          end
          ST_LEN_HI: begin
            len_q <= len_in;
            csum  <= csum ^ bus.i_byte;
          end
          ST_DATA_LO: begin
            lo_q <= bus.i_byte;
            csum <= csum ^ bus.i_byte;
          end
          ST_DATA_HI: begin
            csum       <= csum ^ bus.i_byte;
            bus.o_we   <= 1'b1;
            bus.o_addr <= widx[ROM_ADDR_WIDTH-1:0];
            bus.o_data <= wr_data;
            widx       <= widx + (LEN_W+1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized and directed frames against a frame-level reference model of the loader.
module tb_rom_loader;
  typedef logic [7:0] byte_q_t [$];

  logic i_clk;
  logic i_rst;
  int   n_checks;
  int   n_pass;
  int   we_count;

  rom_loader_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  rom_loader #(
    .ROM_DATA_WIDTH (16),
    .ROM_ADDR_WIDTH (12),
    .TIMEOUT        (8)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Every strobe lasts a single cycle, so sampling just after each edge counts each once.
  always @(posedge i_clk) begin
    #1;
    if (bus.o_we === 1'b1) we_count++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic mk(input logic [63:0] v, input int cnt, output byte_q_t q);
    q.delete();
    for (int i = 0; i < cnt; i++) q.push_back(v[8*(cnt-1-i) +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.i_valid = 1'b0;
      bus.i_byte  = 8'($urandom);
      @(negedge i_clk);
    end
    bus.i_valid = 1'b1;
    bus.i_byte  = b;
    check_val("ready", bus.o_ready, 1);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic start_load();
    bus.i_start = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    check_val("start_busy", bus.o_busy, 1);
    check_val("start_cpu_rst", bus.o_cpu_rst, 0);
  endtask

  // Expected outcome is derived straight from the frame bytes: length, words, XOR.
  task automatic run_frame(input byte_q_t fb, input int gmin, input int gmax, input bit poke);
    int         n;
    int         base;
    bit         exp_ok;
    logic [7:0] x;
    n = int'({fb[1], fb[0]});
    start_load();
    base = we_count;
    if (n > 4096) begin
      send_byte(fb[0], $urandom_range(gmax, gmin));
      send_byte(fb[1], $urandom_range(gmax, gmin));
      check_val("ovs_error", bus.o_error, 1);
      check_val("ovs_busy", bus.o_busy, 0);
      check_val("ovs_writes", we_count - base, 0);
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 2*n; i++) x ^= fb[i];
    exp_ok = (fb[2 + 2*n] == x);
    for (int i = 0; i < fb.size(); i++) begin
      if (poke && i == 2) bus.i_start = 1'b1;
      send_byte(fb[i], $urandom_range(gmax, gmin));
      bus.i_start = 1'b0;
      if (i >= 2 && i < 2 + 2*n && (i % 2) == 1) begin
        check_val("wr_we", bus.o_we, 1);
        check_val("wr_addr", bus.o_addr, (i - 2) / 2);
        check_val("wr_data", bus.o_data, {fb[i], fb[i-1]});
      end
    end
    check_val("end_done", bus.o_done, exp_ok);
    check_val("end_error", bus.o_error, !exp_ok);
    check_val("end_cpu_rst", bus.o_cpu_rst, exp_ok);
    check_val("end_busy", bus.o_busy, 0);
    check_val("end_writes", we_count - base, n);
  endtask

  initial begin
    byte_q_t    fb;
    int         base;
    logic [7:0] x;
    int         n;

    n_checks = 0;
    n_pass   = 0;
    we_count = 0;
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_byte  = 8'h00;
    i_rst = 1'b0;
    #1;
    check_val("rst_ready", bus.o_ready, 0);
    check_val("rst_we", bus.o_we, 0);
    check_val("rst_addr", bus.o_addr, 0);
    check_val("rst_data", bus.o_data, 0);
    check_val("rst_cpu_rst", bus.o_cpu_rst, 0);
    check_val("rst_busy", bus.o_busy, 0);
    check_val("rst_done", bus.o_done, 0);
    check_val("rst_error", bus.o_error, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Bytes offered while idle must not be consumed.
    bus.i_valid = 1'b1;
    bus.i_byte  = 8'hA5;
    check_val("idle_ready", bus.o_ready, 0);
    repeat (3) @(negedge i_clk);
    bus.i_valid = 1'b0;
    check_val("idle_busy", bus.o_busy, 0);

    mk(64'h02_00_34_12_78_56_0A, 7, fb);
    run_frame(fb, 0, 0, 0);
    mk(64'h01_00_CD_AB_00, 5, fb);
    run_frame(fb, 0, 0, 0);
    mk(64'h01_10, 2, fb);
    run_frame(fb, 0, 0, 0);
    mk(64'h00_00_00, 3, fb);
    run_frame(fb, 0, 0, 0);

    // Timeout: eight idle cycles after LEN_LO abort the load.
    start_load();
    base = we_count;
    send_byte(8'h02, 0);
    repeat (7) @(negedge i_clk);
    check_val("tmo_busy_7", bus.o_busy, 1);
    check_val("tmo_error_7", bus.o_error, 0);
    @(negedge i_clk);
    check_val("tmo_error_8", bus.o_error, 1);
    check_val("tmo_busy_8", bus.o_busy, 0);
    check_val("tmo_writes", we_count - base, 0);
    mk(64'h01_00_EF_BE_50, 5, fb);
    run_frame(fb, 0, 2, 0);

    // Seven idle cycles between bytes stay just under the limit.
    mk(64'h02_00_11_22_33_44_44, 7, fb);
    run_frame(fb, 7, 7, 0);

    // A start pulse mid-frame must be ignored.
    mk(64'h01_00_55_66_34, 5, fb);
    run_frame(fb, 0, 1, 1);

    // Reset during DATA_HI abandons the frame.
    start_load();
    base = we_count;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h34, 0);
    bus.i_valid = 1'b1;
    bus.i_byte  = 8'h12;
    i_rst = 1'b0;
    #1;
    check_val("mrst_ready", bus.o_ready, 0);
    check_val("mrst_we", bus.o_we, 0);
    check_val("mrst_addr", bus.o_addr, 0);
    check_val("mrst_data", bus.o_data, 0);
    check_val("mrst_cpu_rst", bus.o_cpu_rst, 0);
    check_val("mrst_busy", bus.o_busy, 0);
    check_val("mrst_done", bus.o_done, 0);
    check_val("mrst_error", bus.o_error, 0);
    repeat (3) @(negedge i_clk);
    bus.i_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    check_val("mrst_idle", bus.o_busy, 0);
    check_val("mrst_writes", we_count - base, 0);

    // Largest legal frame fills every address.
    fb.delete();
    fb.push_back(8'h00);
    fb.push_back(8'h10);
    x = 8'h10;
    for (int i = 0; i < 4096; i++) begin
      fb.push_back(8'($urandom));
      x ^= fb[fb.size()-1];
      fb.push_back(8'($urandom));
      x ^= fb[fb.size()-1];
    end
    fb.push_back(x);
    run_frame(fb, 0, 0, 0);

    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(0, 6);
      fb.delete();
      fb.push_back(8'(n));
      fb.push_back(8'h00);
      x = 8'(n);
      for (int i = 0; i < 2*n; i++) begin
        fb.push_back(8'($urandom));
        x ^= fb[fb.size()-1];
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      fb.push_back(x);
      run_frame(fb, 0, 3, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
